// File: rtl/count_up_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : count_up_stopwatch
// Description : HH:MM:SS count-up stopwatch. The count is kept as six
//               cascaded BCD digits, ticks are one-second enable pulses, and
//               the count saturates at HOUR_LIMIT:59:59 in the OVFL state.
//               Optional feature macro LAP_EN adds a lap (display freeze).
// Revision    : 1.0 - initial release
// ============================================================================
module count_up_stopwatch #(
    parameter int HOUR_LIMIT = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [7:0] hour_bcd,
    output logic [7:0] minute_bcd,
    output logic [7:0] second_bcd,
    output logic       running,
    output logic       overflow,
    output logic       lap_active
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_OVFL  = 2'd3;

    localparam logic [3:0] C_HLIM_TENS = 4'(HOUR_LIMIT / 10);
    localparam logic [3:0] C_HLIM_ONES = 4'(HOUR_LIMIT % 10);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    // Count digits: s0/s1 seconds, m0/m1 minutes, h0/h1 hours (ones/tens)
    logic [3:0] r_s0, r_s1, r_m0, r_m1, r_h0, r_h1;

    logic       w_at_limit;
    logic       w_count_en;
    logic       w_s0_wrap, w_s1_wrap, w_m0_wrap, w_m1_wrap, w_h0_wrap;

    logic [7:0] w_live_hour, w_live_min, w_live_sec;
    logic [7:0] w_disp_hour, w_disp_min, w_disp_sec;
    logic       w_running_nxt, w_overflow_nxt, w_lap_nxt;

    assign w_at_limit = (r_h1 == C_HLIM_TENS) && (r_h0 == C_HLIM_ONES) &&
                        (r_m1 == 4'd5) && (r_m0 == 4'd9) &&
                        (r_s1 == 4'd5) && (r_s0 == 4'd9);

    // clear and start_stop both pre-empt a tick in the same cycle
    assign w_count_en = tick && !clear && !start_stop &&
                        (r_state == S_RUN) && !w_at_limit;

    assign w_s0_wrap = (r_s0 == 4'd9);
    assign w_s1_wrap = (r_s1 == 4'd5);
    assign w_m0_wrap = (r_m0 == 4'd9);
    assign w_m1_wrap = (r_m1 == 4'd5);
    assign w_h0_wrap = (r_h0 == 4'd9);

    assign w_live_hour = {r_h1, r_h0};
    assign w_live_min  = {r_m1, r_m0};
    assign w_live_sec  = {r_s1, r_s0};

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic, priority clear > start_stop > tick
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else if (start_stop) begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_PAUSE;
                S_PAUSE: w_state_nxt = S_RUN;
                default: w_state_nxt = r_state;
            endcase
        end else if (tick && (r_state == S_RUN) && w_at_limit) begin
            w_state_nxt = S_OVFL;
        end
    end

    // Cascaded BCD counter; each digit only advances when all lower digits wrap
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_s0 <= 4'd0;
            r_s1 <= 4'd0;
            r_m0 <= 4'd0;
            r_m1 <= 4'd0;
            r_h0 <= 4'd0;
            r_h1 <= 4'd0;
        end else if (w_count_en) begin
            r_s0 <= w_s0_wrap ? 4'd0 : r_s0 + 4'd1;
            if (w_s0_wrap) begin
                r_s1 <= w_s1_wrap ? 4'd0 : r_s1 + 4'd1;
                if (w_s1_wrap) begin
                    r_m0 <= w_m0_wrap ? 4'd0 : r_m0 + 4'd1;
                    if (w_m0_wrap) begin
                        r_m1 <= w_m1_wrap ? 4'd0 : r_m1 + 4'd1;
                        if (w_m1_wrap) begin
                            // Hours never pass HOUR_LIMIT (<= 99), so h1 cannot overflow
                            r_h0 <= w_h0_wrap ? 4'd0 : r_h0 + 4'd1;
                            if (w_h0_wrap) begin
                                r_h1 <= r_h1 + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

`ifdef LAP_EN
    logic       r_lap_on;
    logic [7:0] r_frz_hour, r_frz_min, r_frz_sec;

    // Lap toggles the freeze outside IDLE; the snapshot is taken when it engages
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_lap_on   <= 1'b0;
            r_frz_hour <= 8'd0;
            r_frz_min  <= 8'd0;
            r_frz_sec  <= 8'd0;
        end else if (lap && (r_state != S_IDLE)) begin
            r_lap_on <= !r_lap_on;
            if (!r_lap_on) begin
                r_frz_hour <= w_live_hour;
                r_frz_min  <= w_live_min;
                r_frz_sec  <= w_live_sec;
            end
        end
    end

    assign w_disp_hour = r_lap_on ? r_frz_hour : w_live_hour;
    assign w_disp_min  = r_lap_on ? r_frz_min  : w_live_min;
    assign w_disp_sec  = r_lap_on ? r_frz_sec  : w_live_sec;
    assign w_lap_nxt   = r_lap_on;
`else
    logic w_unused_lap;

    assign w_unused_lap = lap;
    assign w_disp_hour  = w_live_hour;
    assign w_disp_min   = w_live_min;
    assign w_disp_sec   = w_live_sec;
    assign w_lap_nxt    = 1'b0;
`endif

    // FSM output decode, registered below together with the display
    always_comb begin
        w_running_nxt  = (r_state == S_RUN);
        w_overflow_nxt = (r_state == S_OVFL);
    end

    // Output register stage: everything the outside sees lags state by one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hour_bcd   <= 8'd0;
            minute_bcd <= 8'd0;
            second_bcd <= 8'd0;
            running    <= 1'b0;
            overflow   <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            hour_bcd   <= w_disp_hour;
            minute_bcd <= w_disp_min;
            second_bcd <= w_disp_sec;
            running    <= w_running_nxt;
            overflow   <= w_overflow_nxt;
            lap_active <= w_lap_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/count_up_stopwatch.md
COUNT_UP_STOPWATCH -- requirements
Module: count_up_stopwatch

Interface
REQ-001 Parameter: HOUR_LIMIT, default 23, binary maximum hour value (range 1..99); the count saturates at HOUR_LIMIT:59:59.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: tick  input  1  one-cycle count-enable pulse; one pulse equals one second.
REQ-005 Port: start_stop  input  1  one-cycle pulse; toggles run/pause.
REQ-006 Port: clear  input  1  one-cycle pulse; zeroes the count and returns to IDLE.
REQ-007 Port: lap  input  1  one-cycle pulse; toggles display freeze (LAP_EN only).
REQ-008 Port: hour_bcd  output  8  displayed hours, two BCD digits.
REQ-009 Port: minute_bcd  output  8  displayed minutes, two BCD digits.
REQ-010 Port: second_bcd  output  8  displayed seconds, two BCD digits.
REQ-011 Port: running  output  1  high in state RUN.
REQ-012 Port: overflow  output  1  high in state OVFL.
REQ-013 Port: lap_active  output  1  high while the display is frozen; tied 0 without LAP_EN.

Function
REQ-014 The count SHALL be held internally as six cascaded BCD digits; no binary-to-BCD conversion.
REQ-015 The FSM SHALL have four states: IDLE (count 0, stopped), RUN, PAUSE, OVFL.
REQ-016 Transitions: IDLE --start_stop--> RUN; RUN --start_stop--> PAUSE; PAUSE --start_stop--> RUN; RUN --tick at limit--> OVFL; any state --clear--> IDLE.
REQ-017 In RUN, each tick SHALL increment the count by one second: sec 59->00 carries to min, min 59->00 carries to hour.
REQ-018 A tick in RUN with the count at HOUR_LIMIT:59:59 SHALL leave the count unchanged and enter OVFL.
REQ-019 In OVFL the count SHALL hold; start_stop and tick are ignored; only clear or reset exits.
REQ-020 Priority within one cycle: clear > start_stop > tick.
REQ-021 start_stop and tick in the same cycle in RUN: pause, tick not counted; in IDLE or PAUSE: enter RUN, tick not counted.
REQ-022 Ticks in IDLE or PAUSE SHALL be ignored.
REQ-023 Outputs SHALL be registered: a tick counted at edge n appears on the outputs at edge n+1 (one-cycle latency).
REQ-024 running and overflow SHALL be registered decodes of the FSM state, with the same one-cycle latency.
REQ-025 Every BCD digit SHALL remain in 0..9, tens of minutes/seconds in 0..5, at all times.

Reset
REQ-026 On rst_n low at a clk edge: state IDLE, count 00:00:00, all outputs 0, lap freeze off; this overrides every other input, including mid-count.
REQ-027 Reset SHALL take effect only on a clk edge; no asynchronous path.

Configuration
REQ-028 Macro LAP_EN defined: the lap pulse SHALL toggle a freeze; while frozen, the outputs hold the count captured at the lap edge while counting continues internally; the next lap pulse returns the outputs to live values.
REQ-029 Under LAP_EN, clear SHALL also release the freeze; lap SHALL be honoured in RUN, PAUSE and OVFL, and ignored in IDLE.
REQ-030 Macro LAP_EN undefined: the lap input SHALL be ignored, lap_active tied 0, and the outputs always live.

Verification
REQ-031 Reset, start_stop, 75 ticks -> 00:01:15, running=1.
REQ-032 HOUR_LIMIT=23, count preloaded to 23:59:58 by ticking, 2 ticks -> first 23:59:59, then overflow=1, running=0, count held at 23:59:59; clear -> 00:00:00, overflow=0.
REQ-033 At 00:00:59 in RUN, start_stop and tick in the same cycle -> PAUSE, 00:00:59 held; 5 further ticks -> no change.
REQ-034 At 00:09:59 in RUN, tick -> 00:10:00, then tick -> 00:10:01 (digit carry), one cycle after each tick.
REQ-035 LAP_EN: at 00:00:10 lap, 20 ticks -> outputs 00:00:10, lap_active=1; lap -> 00:00:30.
REQ-036 rst_n low for one edge mid-RUN at 01:02:03 -> next cycle 00:00:00, IDLE, all flags 0.
